tli4970_emulator: RTL and testbench



---
 rtl/tli4970_pkg.sv | 39 +++
 rtl/tli4970_emulator_spi_slave_shift.sv | 106 ++++++++++
 rtl/tli4970_emulator.sv | 148 ++++++++++++++
 tb/tb_tli4970_emulator.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tli4970_pkg.sv
// Shared constants for the TLI4970 current-sensor emulator: frame bit layout,
// register map bases and the SPI slave state encoding.
package tli4970_pkg;

  localparam int FRAME_W     = 16;
  localparam int CURRENT_W   = 13;

  // Bit positions inside a 16-bit sensor frame (MSB first on the wire).
  localparam int MSG_TYPE    = 15;
  localparam int PAR         = 14;
  localparam int OCD         = 13;
  localparam int CURRENT_MSB = 12;

  // Register map: upper address nibble selects the bank, lower nibble the sensor.
  localparam logic [3:0]  CURRENT_BANK = 4'h0;
  localparam logic [3:0]  COUNT_BANK   = 4'h1;
  localparam logic [7:0]  STATUS_ADDR  = 8'h20;
  localparam logic [31:0] DEADBEEF     = 32'hDEAD_BEEF;

  localparam logic [4:0]  BITS_PER_FRAME = 5'd16;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } spi_state_e;

  // Current message: type 0, overcurrent flag 0, parity as supplied.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [CURRENT_W-1:0] current,
                                                     input logic                 par);
    logic [FRAME_W-1:0] frame;
    frame                  = '0;
    frame[MSG_TYPE]        = 1'b0;
    frame[PAR]             = par;
    frame[OCD]             = 1'b0;
    frame[CURRENT_MSB:0]   = current;
    return frame;
  endfunction

endpackage

// File: rtl/tli4970_emulator_spi_slave_shift.sv
// SPI mode-0 slave datapath: pin synchronizers, edge detection, the frame
// shadow shift register, bit counter and frame completion pulses.
module tli4970_emulator_spi_slave_shift
  import tli4970_pkg::*;
#(
  parameter int NUMBER_OF_SENSORS = 2,
  parameter int IDX_W             = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUMBER_OF_SENSORS-1:0] ss_n_i,
  input  logic                         sck_i,
  input  logic                         load,
  input  logic [FRAME_W-1:0]           frame_data,
  input  logic [IDX_W-1:0]             load_idx,
  output logic [NUMBER_OF_SENSORS-1:0] ss_active,
  output logic                         ss_fall_any,
  output logic                         miso,
  output logic                         frame_done,
  output logic                         frame_abort,
  output logic [IDX_W-1:0]             frame_idx,
  output spi_state_e                   state
);

  logic [NUMBER_OF_SENSORS-1:0] ss_meta;
  logic [NUMBER_OF_SENSORS-1:0] ss_sync;
  logic [NUMBER_OF_SENSORS-1:0] ss_prev;
  logic                         sck_meta;
  logic                         sck_sync;
  logic                         sck_prev;
  logic                         sck_rise;
  logic                         sck_fall;
  logic [FRAME_W-1:0]           shreg;
  logic [4:0]                   bitcnt;

  // Selects idle high and sck idles low, so reset the chains to those levels.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ss_meta  <= '1;
      ss_sync  <= '1;
      ss_prev  <= '1;
      sck_meta <= 1'b0;
      sck_sync <= 1'b0;
      sck_prev <= 1'b0;
    end else begin
      ss_meta  <= ss_n_i;
      ss_sync  <= ss_meta;
      ss_prev  <= ss_sync;
      sck_meta <= sck_i;
      sck_sync <= sck_meta;
      sck_prev <= sck_sync;
    end
  end

  assign ss_active   = ~ss_sync;
  assign ss_fall_any = |(ss_prev & ~ss_sync);
  assign sck_rise    = sck_sync & ~sck_prev;
  assign sck_fall    = ~sck_sync & sck_prev;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      shreg       <= '0;
      bitcnt      <= '0;
      miso        <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      frame_idx   <= '0;
    end else begin
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      case (state)
        ST_IDLE: begin
          miso <= 1'b0;
          if (load) begin
            shreg     <= frame_data;
            miso      <= frame_data[MSG_TYPE];
            bitcnt    <= '0;
            frame_idx <= load_idx;
            state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (ss_sync[frame_idx]) begin
            if (bitcnt == BITS_PER_FRAME) frame_done  <= 1'b1;
            else                          frame_abort <= 1'b1;
            miso  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            // Extra clocks past a full frame keep the count pinned at 16.
            if (sck_rise && (bitcnt != BITS_PER_FRAME)) bitcnt <= bitcnt + 5'd1;
            if (sck_fall) begin
              shreg <= {shreg[FRAME_W-2:0], 1'b0};
              miso  <= shreg[FRAME_W-2];
            end
          end
        end
        default: begin
          miso  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/tli4970_emulator.sv
// Emulates up to 16 TLI4970 sensors on a shared SPI bus with an Avalon-MM
// register file. Define TLI4970_EMU_PARITY_EN for real parity and corrupt-frame injection.
module tli4970_emulator
  import tli4970_pkg::*;
#(
  parameter int NUMBER_OF_SENSORS = 2,
  parameter int CLOCK_SPEED_HZ    = 50_000_000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [7:0]                   address,
  input  logic                         write,
  input  logic [31:0]                  writedata,
  input  logic                         read,
  output logic [31:0]                  readdata,
  output logic                         waitrequest,
  input  logic [NUMBER_OF_SENSORS-1:0] ss_n_i,
  input  logic                         sck_i,
  output logic                         miso_o
);

  localparam int IDX_W = (NUMBER_OF_SENSORS > 1) ? $clog2(NUMBER_OF_SENSORS) : 1;

  if (NUMBER_OF_SENSORS < 1 || NUMBER_OF_SENSORS > 16 || CLOCK_SPEED_HZ < 8) begin : g_bad_cfg
    $error("tli4970_emulator: NUMBER_OF_SENSORS must be 1..16 and CLOCK_SPEED_HZ >= 8");
  end

  logic [CURRENT_W-1:0]         current_q [NUMBER_OF_SENSORS];
  logic [31:0]                  count_q   [NUMBER_OF_SENSORS];
  logic                         collision_q;
  logic                         rd_done;
  logic [31:0]                  rd_mux;
  logic                         addr_in_range;

  logic [NUMBER_OF_SENSORS-1:0] ss_active;
  logic                         ss_fall_any;
  logic                         frame_done;
  logic                         frame_abort;
  logic [IDX_W-1:0]             frame_idx;
  spi_state_e                   spi_state;
  logic                         start;
  logic [IDX_W-1:0]             start_idx;
  logic [4:0]                   n_active;
  logic                         frame_par;
  logic [FRAME_W-1:0]           frame_data;
  logic                         unused_bits;

  // Lowest active select wins; also count how many are low for collision tracking.
  always_comb begin
    start_idx = '0;
    n_active  = '0;
    for (int k = NUMBER_OF_SENSORS - 1; k >= 0; k--) begin
      if (ss_active[k]) start_idx = IDX_W'(k);
      n_active = n_active + 5'(ss_active[k]);
    end
  end

  assign start = (spi_state == ST_IDLE) && ss_fall_any;

`ifdef TLI4970_EMU_PARITY_EN
  logic [NUMBER_OF_SENSORS-1:0] corrupt_q;

  assign frame_par   = (^current_q[start_idx]) ^ corrupt_q[start_idx];
  assign unused_bits = ^{writedata[30:13], frame_abort};

  // An armed corruption is spent by the next frame started on that sensor.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      corrupt_q <= '0;
    end else begin
      for (int i = 0; i < NUMBER_OF_SENSORS; i++) begin
        if (start && (start_idx == IDX_W'(i))) corrupt_q[i] <= 1'b0;
        if (write && (address == 8'(i)) && writedata[31]) corrupt_q[i] <= 1'b1;
      end
    end
  end
`else
  assign frame_par   = 1'b0;
  assign unused_bits = ^{writedata[31:13], frame_abort};
`endif

  // Register outputs of current_q are sampled, so a same-cycle write lands in the next frame.
  assign frame_data = build_frame(current_q[start_idx], frame_par);

  tli4970_emulator_spi_slave_shift #(
    .NUMBER_OF_SENSORS (NUMBER_OF_SENSORS),
    .IDX_W             (IDX_W)
  ) u_shift (
    .clock       (clock),
    .reset       (reset),
    .ss_n_i      (ss_n_i),
    .sck_i       (sck_i),
    .load        (start),
    .frame_data  (frame_data),
    .load_idx    (start_idx),
    .ss_active   (ss_active),
    .ss_fall_any (ss_fall_any),
    .miso        (miso_o),
    .frame_done  (frame_done),
    .frame_abort (frame_abort),
    .frame_idx   (frame_idx),
    .state       (spi_state)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUMBER_OF_SENSORS; i++) begin
        current_q[i] <= '0;
        count_q[i]   <= '0;
      end
      collision_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUMBER_OF_SENSORS; i++) begin
        if (write && (address == 8'(i))) current_q[i] <= writedata[CURRENT_W-1:0];
        if (frame_done && (frame_idx == IDX_W'(i))) count_q[i] <= count_q[i] + 32'd1;
      end
      if (write && (address == STATUS_ADDR)) collision_q <= 1'b0;
      if (n_active > 5'd1)                   collision_q <= 1'b1;
    end
  end

  assign addr_in_range = ({1'b0, address[3:0]} < 5'(NUMBER_OF_SENSORS));

  always_comb begin
    rd_mux = DEADBEEF;
    if ((address[7:4] == CURRENT_BANK) && addr_in_range)
      rd_mux = {{(32-CURRENT_W){1'b0}}, current_q[address[IDX_W-1:0]]};
    else if ((address[7:4] == COUNT_BANK) && addr_in_range)
      rd_mux = count_q[address[IDX_W-1:0]];
    else if (address == STATUS_ADDR)
      rd_mux = {31'd0, collision_q};
  end

  // Avalon handshake: a read stalls exactly one cycle (waitrequest high) and
  // readdata is valid on the cycle waitrequest drops; writes never stall.
  assign waitrequest = read && !rd_done;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_done  <= 1'b0;
      readdata <= '0;
    end else begin
      rd_done <= read && !rd_done;
      if (read && !rd_done) readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_tli4970_emulator.sv
// Directed bench for tli4970_emulator: SPI mode-0 master driver, Avalon tasks and a
// register/frame model checked against miso every clock and against every read.
module tb_tli4970_emulator;

  localparam int N    = 2;
  localparam int HALF = 25;

`ifdef TLI4970_EMU_PARITY_EN
  localparam logic [15:0] EXP_0ABC = 16'h4ABC;
  localparam logic [15:0] EXP_0001 = 16'h4001;
  localparam logic [15:0] EXP_1FFF = 16'h5FFF;
`else
  localparam logic [15:0] EXP_0ABC = 16'h0ABC;
  localparam logic [15:0] EXP_0001 = 16'h0001;
  localparam logic [15:0] EXP_1FFF = 16'h1FFF;
`endif

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #10 clock = ~clock;

  logic [7:0]   address   = '0;
  logic         write     = 1'b0;
  logic [31:0]  writedata = '0;
  logic         read      = 1'b0;
  logic [31:0]  readdata;
  logic         waitrequest;
  logic [N-1:0] ss_n      = '1;
  logic         sck       = 1'b0;
  logic         miso;

  tli4970_emulator #(
    .NUMBER_OF_SENSORS (N),
    .CLOCK_SPEED_HZ    (50_000_000)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .address     (address),
    .write       (write),
    .writedata   (writedata),
    .read        (read),
    .readdata    (readdata),
    .waitrequest (waitrequest),
    .ss_n_i      (ss_n),
    .sck_i       (sck),
    .miso_o      (miso)
  );

  int checks = 0;
  int errors = 0;

  // behavioural model of the register file
  logic [12:0] m_cur [N];
  logic [31:0] m_cnt [N];
  logic        m_arm [N];
  logic        m_coll;
  logic        exp_miso = 1'b0;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cur[i] = '0;
      m_cnt[i] = '0;
      m_arm[i] = 1'b0;
    end
    m_coll = 1'b0;
  endtask

  function automatic logic [31:0] m_read(input logic [7:0] a);
    if (a < N)                      return {19'd0, m_cur[a]};
    if (a >= 8'h10 && a < 8'h10 + N) return m_cnt[a - 8'h10];
    if (a == 8'h20)                 return {31'd0, m_coll};
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [15:0] m_frame(input int i);
    logic par;
`ifdef TLI4970_EMU_PARITY_EN
    par = (($countones(m_cur[i]) % 2) == 1) ^ m_arm[i];
`else
    par = 1'b0;
`endif
    return {1'b0, par, 1'b0, m_cur[i]};
  endfunction

  // driver tasks
  task automatic av_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clock);
    address = a; writedata = d; write = 1'b1;
    @(negedge clock);
    write = 1'b0;
    if (a < N) begin
      m_cur[a] = d[12:0];
`ifdef TLI4970_EMU_PARITY_EN
      if (d[31]) m_arm[a] = 1'b1;
`endif
    end
    if (a == 8'h20) m_coll = 1'b0;
  endtask

  task automatic av_read(input logic [7:0] a, output logic [31:0] data, output int waits);
    waits = 0;
    @(negedge clock);
    address = a; read = 1'b1;
    #1;
    while (waitrequest && waits < 8) begin
      waits++;
      @(negedge clock);
      #1;
    end
    data = readdata;
    read = 1'b0;
  endtask

  task automatic check_read(input logic [7:0] a, input string name);
    logic [31:0] data;
    int          waits;
    av_read(a, data, waits);
    compare(name, data, m_read(a));
    compare({name, "_waits"}, waits, 1);
  endtask

  // Every settled clock of an SPI half period must show the expected miso bit.
  task automatic half_period();
    for (int k = 0; k < HALF; k++) begin
      @(negedge clock);
      if (k >= 2) compare("miso", miso, exp_miso);
    end
  endtask

  task automatic spi_frame(input logic [N-1:0] mask, input int nedges, input int wr_bit,
                           input logic [7:0] wr_addr, input logic [31:0] wr_data,
                           output logic [15:0] rx);
    int          w;
    logic [15:0] word;
    w = 0;
    for (int k = N - 1; k >= 0; k--) if (mask[k]) w = k;
    if ($countones(mask) > 1) m_coll = 1'b1;
    word     = m_frame(w);
    m_arm[w] = 1'b0;
    rx       = '0;
    exp_miso = word[15];
    ss_n     = ~mask;
    half_period();
    for (int b = 0; b < nedges; b++) begin
      sck = 1'b1;
      if (b < 16) rx = {rx[14:0], miso};
      compare("miso_rise", miso, exp_miso);
      if (b == wr_bit) av_write(wr_addr, wr_data);
      half_period();
      sck      = 1'b0;
      exp_miso = (b < 15) ? word[14 - b] : 1'b0;
      half_period();
    end
    ss_n = '1;
    if (nedges >= 16) m_cnt[w] = m_cnt[w] + 32'd1;
    exp_miso = 1'b0;
    repeat (3) @(negedge clock);
    compare("miso_end", miso, 1'b0);
    half_period();
  endtask

  initial begin
    logic [15:0] rx;
    logic [31:0] data;
    int          waits;

    model_reset();
    repeat (3) @(negedge clock);
    compare("reset_readdata", readdata, 32'd0);
    compare("reset_waitrequest", waitrequest, 1'b0);
    compare("reset_miso", miso, 1'b0);
    reset = 1'b0;
    half_period();
    check_read(8'h00, "cur0_reset");
    check_read(8'h10, "cnt0_reset");
    check_read(8'h20, "status_reset");

    // basic frame on sensor 0
    av_write(8'h00, 32'h0000_0ABC);
    spi_frame(2'b01, 16, -1, 8'h00, 32'h0, rx);
    compare("frame0_lit", rx, EXP_0ABC);
    check_read(8'h10, "cnt0");
    av_read(8'h10, data, waits);
    compare("cnt0_lit", data, 32'd1);

    // unmapped reads
    av_read(8'h05, data, waits);
    compare("unmapped_lit", data, 32'hDEAD_BEEF);
    compare("unmapped_waits_lit", waits, 1);
    check_read(8'h12, "cnt_oob");
    check_read(8'h30, "unmapped_30");

    // write during a frame only affects the next one
    av_write(8'h01, 32'h0000_0001);
    spi_frame(2'b10, 16, 8, 8'h01, 32'h0000_1FFF, rx);
    compare("midwrite_old_lit", rx, EXP_0001);
    spi_frame(2'b10, 16, -1, 8'h00, 32'h0, rx);
    compare("midwrite_new_lit", rx, EXP_1FFF);
    check_read(8'h01, "cur1");
    check_read(8'h11, "cnt1");

    // aborted frame after 10 clocks
    spi_frame(2'b01, 10, -1, 8'h00, 32'h0, rx);
    av_read(8'h10, data, waits);
    compare("abort_cnt0_lit", data, 32'd1);

    // collision: sensor 0 wins
    spi_frame(2'b11, 16, -1, 8'h00, 32'h0, rx);
    compare("collision_frame_lit", rx, EXP_0ABC);
    av_read(8'h20, data, waits);
    compare("collision_status_lit", data, 32'd1);
    av_write(8'h20, 32'h0);
    av_read(8'h20, data, waits);
    compare("collision_clear_lit", data, 32'd0);
    check_read(8'h10, "cnt0_after_coll");
    check_read(8'h11, "cnt1_after_coll");

    // more than 16 clocks still counts
    spi_frame(2'b01, 20, -1, 8'h00, 32'h0, rx);
    compare("long_frame_lit", rx, EXP_0ABC);
    check_read(8'h10, "cnt0_long");

    // unmapped writes are ignored
    av_write(8'h07, 32'h0000_1234);
    av_write(8'h40, 32'h0000_0555);
    check_read(8'h00, "cur0_after_unmapped");
    check_read(8'h01, "cur1_after_unmapped");

`ifdef TLI4970_EMU_PARITY_EN
    av_write(8'h01, 32'h8000_1FFF);
    spi_frame(2'b10, 16, -1, 8'h00, 32'h0, rx);
    compare("corrupt_frame_lit", rx, 16'h1FFF);
    spi_frame(2'b10, 16, -1, 8'h00, 32'h0, rx);
    compare("after_corrupt_lit", rx, 16'h5FFF);
`endif

    // reset in the middle of a frame
    av_write(8'h00, 32'h0000_0123);
    ss_n = 2'b10;
    repeat (10) @(negedge clock);
    for (int b = 0; b < 6; b++) begin
      sck = 1'b1;
      repeat (HALF) @(negedge clock);
      sck = 1'b0;
      repeat (HALF) @(negedge clock);
    end
    reset = 1'b1;
    #1;
    compare("midreset_miso", miso, 1'b0);
    compare("midreset_readdata", readdata, 32'd0);
    @(negedge clock);
    ss_n = '1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    model_reset();
    half_period();
    av_read(8'h00, data, waits);
    compare("post_reset_cur0_lit", data, 32'd0);
    check_read(8'h10, "post_reset_cnt0");
    check_read(8'h11, "post_reset_cnt1");
    check_read(8'h20, "post_reset_status");
    spi_frame(2'b01, 16, -1, 8'h00, 32'h0, rx);
    compare("post_reset_frame_lit", rx, 16'h0000);
    check_read(8'h10, "post_reset_cnt0_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
